// File: rtl/instr_queue.sv
// instr_queue: dual-write / dual-read FWFT instruction queue between fetch scheduler and decode.
// Optional same-cycle bypass of an empty queue: define INSTR_QUEUE_BYPASS_EN.
module instr_queue #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write1,
    input  logic                       write2,
    input  logic [ENTRY_W-1:0]         wdata1,
    input  logic [ENTRY_W-1:0]         wdata2,
    output logic                       stall,
    input  logic                       flush,
    input  logic                       pop1,
    input  logic                       pop2,
    output logic                       valid1,
    output logic                       valid2,
    output logic [ENTRY_W-1:0]         rdata1,
    output logic [ENTRY_W-1:0]         rdata2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_head, r_tail;
    logic [CW-1:0]      r_count;
    logic               w_byp, w_push1, w_push2, w_pop1, w_pop2;
    logic [1:0]         w_npush, w_npop;
    logic [AW-1:0]      w_head1, w_tail1;
`ifdef INSTR_QUEUE_BYPASS_EN
    assign w_byp = (r_count == '0) & (write1 | write2) & ~flush;
`else
    assign w_byp = 1'b0;
`endif
    assign stall   = r_count > CW'(DEPTH - 2);
    assign count   = r_count;
    assign w_head1 = r_head + AW'(1);
    assign w_tail1 = r_tail + AW'(1);
    assign valid1  = (r_count != '0) | w_byp;
    assign valid2  = (r_count >= CW'(2)) | (w_byp & write1 & write2);
    assign rdata1  = w_byp ? (write1 ? wdata1 : wdata2) : r_mem[r_head];
    assign rdata2  = w_byp ? wdata2 : r_mem[w_head1];
    // a stalled write is dropped whole, so a single accepted push always has room for two
    assign w_push1 = (write1 | write2) & ~stall & ~flush;
    assign w_push2 = write1 & write2 & ~stall & ~flush;
    assign w_pop1  = pop1 & valid1 & ~flush;
    assign w_pop2  = pop2 & w_pop1 & valid2;
    assign w_npush = {1'b0, w_push1} + {1'b0, w_push2};
    assign w_npop  = {1'b0, w_pop1} + {1'b0, w_pop2};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_npop);
            r_tail  <= r_tail + AW'(w_npush);
            r_count <= r_count + CW'(w_npush) - CW'(w_npop);
        end
    end
    // bypassed entries are written too; head simply advances past them when popped
    always_ff @(posedge clk) begin
        if (w_push1) r_mem[r_tail] <= write1 ? wdata1 : wdata2;
        if (w_push2) r_mem[w_tail1] <= wdata2;
    end
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed stimulus with a scoreboard of expected entries checked by a decode-side monitor.
module tb_instr_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write1 = 1'b0, write2 = 1'b0, flush = 1'b0, pop1 = 1'b0, pop2 = 1'b0;
    logic [63:0] wdata1 = '0, wdata2 = '0;
    logic        stall, valid1, valid2;
    logic [63:0] rdata1, rdata2;
    logic [3:0]  count;
    logic [63:0] sb [$];
    int          n_cmp = 0, n_bad = 0;
    logic [63:0] exp_e;

    instr_queue #(.DEPTH(8), .ENTRY_W(64)) dut (
        .clk(clk), .rst(rst), .write1(write1), .write2(write2), .wdata1(wdata1), .wdata2(wdata2),
        .stall(stall), .flush(flush), .pop1(pop1), .pop2(pop2), .valid1(valid1), .valid2(valid2),
        .rdata1(rdata1), .rdata2(rdata2), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {32'h0000_0013 + pc, pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one cycle of stimulus; acc says whether the hand-derived outcome is that the writes are accepted
    task automatic drive(input logic w1, input logic w2, input logic [63:0] d1, input logic [63:0] d2,
                         input logic p1, input logic p2, input logic f, input logic acc);
        write1 = w1; write2 = w2; wdata1 = d1; wdata2 = d2; pop1 = p1; pop2 = p2; flush = f;
        if (f) sb.delete();
        else if (acc) begin
            if (w1) sb.push_back(d1);
            if (w2) sb.push_back(d2);
        end
        @(posedge clk);
        #1;
        write1 = 0; write2 = 0; pop1 = 0; pop2 = 0; flush = 0;
    endtask

    // decode-side monitor: every honoured pop must deliver the next expected entry
    always @(negedge clk) begin
        if (!rst && !flush && pop1 && valid1) begin
            if (sb.size() == 0) chk("unexpected_rdata1", rdata1, 64'hx);
            else begin exp_e = sb.pop_front(); chk("rdata1", rdata1, exp_e); end
            if (pop2 && valid2) begin
                if (sb.size() == 0) chk("unexpected_rdata2", rdata2, 64'hx);
                else begin exp_e = sb.pop_front(); chk("rdata2", rdata2, exp_e); end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'({valid1, valid2}), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        // dual write, FWFT presentation one cycle later
        drive(1, 1, 64'h00014137_00000000, 64'h0001E237_00000004, 0, 0, 0, 1);
        chk("dual_count", 64'(count), 64'd2);
        chk("dual_rdata1", rdata1, 64'h00014137_00000000);
        chk("dual_rdata2", rdata2, 64'h0001E237_00000004);
        chk("dual_valid", 64'({valid1, valid2}), 64'b11);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("dual_drain_count", 64'(count), 64'd0);
        // fill and stall: stall only once fewer than two slots are free
        drive(1, 1, ent(32'h100), ent(32'h104), 0, 0, 0, 1);
        drive(1, 1, ent(32'h108), ent(32'h10c), 0, 0, 0, 1);
        drive(1, 1, ent(32'h110), ent(32'h114), 0, 0, 0, 1);
        chk("fill6_count", 64'(count), 64'd6);
        chk("fill6_stall", 64'(stall), 64'd0);
        drive(1, 1, ent(32'h118), ent(32'h11c), 0, 0, 0, 1);
        chk("full_count", 64'(count), 64'd8);
        chk("full_stall", 64'(stall), 64'd1);
        drive(1, 1, ent(32'h120), ent(32'h124), 0, 0, 0, 0);
        chk("drop_count", 64'(count), 64'd8);
        drive(1, 0, ent(32'h128), 0, 1, 1, 0, 0);
        chk("drop_pop_count", 64'(count), 64'd6);
        chk("drop_pop_stall", 64'(stall), 64'd0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        chk("pop2_alone_count", 64'(count), 64'd6);
        drive(0, 1, 0, ent(32'h130), 1, 0, 0, 1);
        chk("compact_count", 64'(count), 64'd6);
        drive(1, 0, ent(32'h134), 0, 0, 0, 0, 1);
        chk("seven_count", 64'(count), 64'd7);
        chk("seven_stall", 64'(stall), 64'd1);
        drive(1, 1, ent(32'h138), ent(32'h13c), 0, 0, 0, 0);
        chk("seven_drop_count", 64'(count), 64'd7);
        repeat (3) drive(0, 0, 0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("drain_count", 64'(count), 64'd0);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("underflow_count", 64'(count), 64'd0);
        chk("underflow_valid", 64'({valid1, valid2}), 64'd0);
        // wrap: steady push2/pop2 crossing the pointer boundary several times
        drive(1, 1, ent(32'h1000), ent(32'h1004), 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            drive(1, 1, ent(32'h1008 + 32'(8 * i)), ent(32'h100c + 32'(8 * i)), 1, 1, 0, 1);
        chk("wrap_count", 64'(count), 64'd2);
        drive(0, 0, 0, 0, 1, 1, 0, 0);
        chk("wrap_drain_count", 64'(count), 64'd0);
        // flush wins over same-cycle writes and pops
        drive(1, 1, ent(32'h200), ent(32'h204), 0, 0, 0, 1);
        drive(1, 0, ent(32'h208), 0, 0, 0, 0, 1);
        chk("preflush_count", 64'(count), 64'd3);
        drive(1, 1, ent(32'h20c), ent(32'h210), 1, 0, 1, 0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'({valid1, valid2}), 64'd0);
        // bypass: write into empty queue with a same-cycle pop
        write1 = 1; wdata1 = ent(32'h40); pop1 = 1;
        sb.push_back(ent(32'h40));
        #2;
`ifdef INSTR_QUEUE_BYPASS_EN
        chk("bypass_valid1", 64'(valid1), 64'd1);
        chk("bypass_rdata1", rdata1, ent(32'h40));
        @(posedge clk); #1;
        write1 = 0; pop1 = 0;
        chk("bypass_count", 64'(count), 64'd0);
`else
        chk("bypass_valid1", 64'(valid1), 64'd0);
        @(posedge clk); #1;
        write1 = 0; pop1 = 0;
        chk("bypass_count", 64'(count), 64'd1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
`endif
        chk("bypass_end_count", 64'(count), 64'd0);
        // asynchronous reset with entries in flight
        drive(1, 1, ent(32'h300), ent(32'h304), 0, 0, 0, 1);
        drive(1, 1, ent(32'h308), ent(32'h30c), 0, 0, 0, 1);
        drive(1, 0, ent(32'h310), 0, 0, 0, 0, 1);
        chk("prereset_count", 64'(count), 64'd5);
        #2 rst = 1;
        #1;
        chk("async_reset_count", 64'(count), 64'd0);
        chk("async_reset_valid", 64'({valid1, valid2}), 64'd0);
        chk("async_reset_stall", 64'(stall), 64'd0);
        sb.delete();
        @(posedge clk); #1 rst = 0;
        drive(1, 0, ent(32'h400), 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        chk("post_reset_count", 64'(count), 64'd0);
        chk("scoreboard_left", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
